// File: rtl/instr_prefetch_if.sv
// Prefetch bus bundle: memory read channel, CPU instruction channel and branch flush.
interface instr_prefetch_if;
  logic        flush;
  logic [10:0] flush_addr;
  logic        mem_req;
  logic [10:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [10:0] instr_pc;
  logic        instr_ready;

  modport master (
    input  flush, flush_addr, mem_rvalid, mem_rdata, instr_ready,
    output mem_req, mem_addr, instr_valid, instr, instr_pc
  );

  modport slave (
    output flush, flush_addr, mem_rvalid, mem_rdata, instr_ready,
    input  mem_req, mem_addr, instr_valid, instr, instr_pc
  );
endinterface

// File: rtl/instr_prefetch.sv
// Instruction prefetcher: single outstanding memory read feeding a DEPTH-entry
// {pc, instr} FIFO, with branch flush that drops any in-flight read.
module instr_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [10:0] RESET_PC = 11'd0
) (
  input logic               clk,
  input logic               resetn,
  instr_prefetch_if.master  bus
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t          state;
  logic [31:0]     fifo_data [DEPTH];
  logic [10:0]     fifo_pc   [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [10:0]     fetch_pc;
  logic [10:0]     req_pc;
  logic            req;
  logic            push;
  logic            pop;
  logic            head_valid;

  always_comb begin
    head_valid = (count != '0);
    // resetn gate keeps mem_req low while reset is held, since state already reads IDLE
    req  = resetn && (state == IDLE) && !bus.flush && (count < CW'(DEPTH));
    push = (state == WAIT) && bus.mem_rvalid && !bus.flush;
    pop  = head_valid && bus.instr_ready;
  end

  assign bus.mem_req     = req;
  assign bus.mem_addr    = fetch_pc;
  assign bus.instr_valid = head_valid;
  assign bus.instr       = head_valid ? fifo_data[rd_ptr] : '0;
  assign bus.instr_pc    = head_valid ? fifo_pc[rd_ptr]   : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
    end else if (bus.flush) begin
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fetch_pc <= bus.flush_addr;
      // an in-flight read must still be absorbed unless it returns this cycle
      if (state != IDLE) state <= bus.mem_rvalid ? IDLE : DROP;
    end else begin
      unique case (state)
        IDLE: if (req) begin
          state    <= WAIT;
          req_pc   <= fetch_pc;
          fetch_pc <= fetch_pc + 11'd1;
        end
        WAIT, DROP: if (bus.mem_rvalid) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= bus.mem_rdata;
      fifo_pc[wr_ptr]   <= req_pc;
    end
  end
endmodule

// File: doc/instr_prefetch.md
INSTR_PREFETCH -- requirements
Module: instr_prefetch

Interface
REQ-001 Parameter DEPTH, default 4, meaning FIFO entry count; the block SHALL support only powers of 2 from 2 to 16.
REQ-002 Parameter RESET_PC, default 11'd0, meaning the first fetch address after reset.
REQ-003 clk  input  1  meaning system clock; all state SHALL update on its rising edge.
REQ-004 resetn  input  1  meaning reset; the block SHALL treat it as asynchronous and active-low.
REQ-005 flush  input  1  meaning branch taken; the block SHALL sample it synchronously.
REQ-006 flush_addr  input  11  meaning branch target, valid while flush=1.
REQ-007 mem_req  output  1  meaning instruction read request, one cycle per request.
REQ-008 mem_addr  output  11  meaning read address, valid while mem_req=1.
REQ-009 mem_rvalid  input  1  meaning read data return; it arrives 1 or more cycles after mem_req.
REQ-010 mem_rdata  input  32  meaning instruction word, valid while mem_rvalid=1.
REQ-011 instr_valid  output  1  meaning the FIFO head is valid.
REQ-012 instr  output  32  meaning FIFO head instruction; it SHALL be 32'd0 (NOOP) when instr_valid=0.
REQ-013 instr_pc  output  11  meaning FIFO head address; it SHALL be 11'd0 when instr_valid=0.
REQ-014 instr_ready  input  1  meaning the CPU consumes the head.

Function
REQ-015 The block SHALL hold a 32+11-bit FIFO of DEPTH entries, a count of 0..DEPTH, an 11-bit fetch_pc, and an FSM with states IDLE, WAIT and DROP.
REQ-016 mem_req SHALL be combinational and equal to (state==IDLE && !flush && count<DEPTH); mem_addr SHALL equal fetch_pc.
REQ-017 On mem_req=1 the FSM SHALL move IDLE->WAIT and fetch_pc SHALL advance by 1 modulo 2^11 (11'h7FF wraps to 11'h000).
REQ-018 Only one request SHALL be outstanding; mem_rvalid outside WAIT/DROP SHALL be ignored.
REQ-019 In WAIT with mem_rvalid=1 and flush=0, the block SHALL push {mem_addr of that request, mem_rdata} and move WAIT->IDLE; the next request SHALL come no earlier than the following cycle.
REQ-020 Pop SHALL occur when instr_valid && instr_ready; outputs SHALL be driven combinationally from the FIFO head, so latency is 0 cycles.
REQ-021 A push and a pop in the same cycle SHALL leave count unchanged.
REQ-022 Pushes never occur when full: the gating in REQ-016 reserves a slot, and count+outstanding SHALL never exceed DEPTH.
REQ-023 Flush SHALL have priority over push and pop: count SHALL go to 0, read/write pointers SHALL reset, fetch_pc SHALL load flush_addr, and instr_valid SHALL be 0 in the following cycle.
REQ-024 Flush in IDLE SHALL leave the FSM in IDLE.
REQ-025 Flush in WAIT with mem_rvalid=0 SHALL move the FSM to DROP.
REQ-026 Flush in WAIT with mem_rvalid=1 SHALL discard the data and move the FSM to IDLE.
REQ-027 In DROP, mem_rvalid SHALL discard the data and move the FSM to IDLE; flush in DROP SHALL reload fetch_pc and keep the FSM in DROP.
REQ-028 While flush=1, mem_req SHALL be 0.
REQ-029 The first request after a flush SHALL use address flush_addr.

Reset
REQ-030 While resetn=0 the block SHALL hold: state=IDLE, count=0, pointers=0, fetch_pc=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
REQ-031 During reset, mem_req SHALL be 0 regardless of other inputs.
REQ-032 Reset asserted mid-request SHALL abandon the outstanding read.
REQ-033 Any mem_rvalid arriving after reset release with no request issued SHALL be ignored.
REQ-034 After reset release, the first mem_req SHALL occur in the first cycle resetn=1, with mem_addr=RESET_PC.

Verification
REQ-035 Streaming: memory latency 1, instr_ready=1, mem_rdata=addr+32'h100 -> instrs at pc 0,1,2,3 appear in order with instr=32'h100,101,102,103 and none are lost or duplicated.
REQ-036 Full: instr_ready=0, DEPTH=4 -> exactly 4 requests (addr 0..3); mem_req stays 0; count=4 holds. Raising ready pops pc 0 and a request for addr 4 follows.
REQ-037 Flush in WAIT: request addr 5 outstanding, flush with flush_addr=11'h040, rvalid 3 cycles later -> the addr-5 data is dropped; next request addr 11'h040; FIFO empty; instr=0.
REQ-038 Flush coincident with rvalid and pop: FIFO holding 2 entries, flush=1 with flush_addr=11'h010 -> count=0; returned data discarded; FSM=IDLE; next mem_addr=11'h010.
REQ-039 Wrap: flush_addr=11'h7FE, streaming -> pcs 7FE, 7FF, 000, 001 delivered in order.
REQ-040 Async reset: resetn driven low mid-WAIT between clock edges -> outputs go to reset values immediately; a later stray rvalid is ignored; the first request after release has mem_addr=RESET_PC.
